// File: rtl/branch_scanner_if.sv
// Purpose: bundles the fetch/control-facing signals of the forward-branch
//          skip engine.
// Ports (master = fetch/state-logic side, slave = branch_scanner):
//   start        master->slave  one-cycle pulse: begin skip scan
//   instr_valid  master->slave  instr_in carries a valid op_code
//   instr_in     master->slave  op_code from fetch
//   instr_out    slave->master  op_code to core_control (NOP unless idle)
//   pc_advance   slave->master  request fetch to advance PC
//   busy         slave->master  scan or error in progress
//   done         slave->master  one-cycle pulse: matching CBB consumed
//   overflow     slave->master  sticky nesting-depth overflow
//   depth        slave->master  current nesting depth
interface branch_scanner_if #(
   parameter int unsigned DEPTH_W = 8,
   parameter int unsigned OP_W    = 4
);
   logic               start;
   logic               instr_valid;
   logic [OP_W-1:0]    instr_in;
   logic [OP_W-1:0]    instr_out;
   logic               pc_advance;
   logic               busy;
   logic               done;
   logic               overflow;
   logic [DEPTH_W-1:0] depth;

   modport master (
      output start, instr_valid, instr_in,
      input  instr_out, pc_advance, busy, done, overflow, depth
   );

   modport slave (
      input  start, instr_valid, instr_in,
      output instr_out, pc_advance, busy, done, overflow, depth
   );
endinterface

// File: rtl/branch_scanner.sv
// Purpose: forward-branch skip engine between instruction fetch and
//          core_control. On start it consumes fetched op_codes, tracks
//          CBF/CBB nesting and emits NOP until the matching CBB is consumed;
//          otherwise instructions pass through unchanged.
// Ports:
//   clock  core clock, rising-edge state updates
//   reset  asynchronous, active-high reset
//   bus    branch_scanner_if.slave (start/instr_valid/instr_in in;
//          instr_out/pc_advance/busy/done/overflow/depth out)
module branch_scanner #(
   parameter int unsigned       DEPTH_W = 8,
   parameter int unsigned       OP_W    = 4,
   parameter logic [OP_W-1:0]   NOP_OP  = '0,
   parameter logic [OP_W-1:0]   CBF_OP  = OP_W'(7),
   parameter logic [OP_W-1:0]   CBB_OP  = OP_W'(8)
) (
   input  logic               clock,
   input  logic               reset,
   branch_scanner_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE,
      ERROR
   } state_t;

   localparam logic [DEPTH_W-1:0] ONE = DEPTH_W'(1);

   state_t             state;
   logic [DEPTH_W-1:0] depth_q;
   logic               overflow_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;   // high exactly in IDLE: instr_in goes straight through

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         depth_q    <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  depth_q <= ONE;
                  state   <= SCAN;
                  busy_q  <= 1'b1;
                  pass_q  <= 1'b0;
               end
            end
            SCAN: begin
               if (bus.instr_valid) begin
                  if (bus.instr_in == CBF_OP) begin
                     // Saturate into ERROR rather than wrap the counter.
                     if (depth_q == '1) begin
                        overflow_q <= 1'b1;
                        state      <= ERROR;
                     end else begin
                        depth_q <= depth_q + ONE;
                     end
                  end else if (bus.instr_in == CBB_OP) begin
                     if (depth_q == ONE) begin
                        depth_q <= '0;
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        depth_q <= depth_q - ONE;
                     end
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               pass_q <= 1'b1;
            end
            ERROR: begin
               state <= ERROR;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               pass_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.instr_out  = pass_q ? bus.instr_in : NOP_OP;
   assign bus.pc_advance = (state == SCAN) && bus.instr_valid;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.overflow   = overflow_q;
   assign bus.depth      = depth_q;

endmodule

// File: tb/tb_branch_scanner.sv
// Purpose: self-checking bench for branch_scanner. Two instances (8-bit and
//          2-bit depth counters) share one stimulus stream; a behavioural model
//          per instance is compared against every output on each falling edge,
//          and directed sequences add literal expectations.
// Ports: none (top-level bench).
module tb_branch_scanner;

   localparam logic [3:0] NOP = 4'd0, INC = 4'd1, DEC = 4'd2, MVR = 4'd3,
                          MVL = 4'd4, PSH = 4'd5, POP = 4'd6, CBF = 4'd7,
                          CBB = 4'd8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       instr_valid = 1'b0;
   logic [3:0] instr_in = NOP;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clock = ~clock;

   branch_scanner_if #(.DEPTH_W(8), .OP_W(4)) b8 ();
   branch_scanner_if #(.DEPTH_W(2), .OP_W(4)) b2 ();

   assign b8.start = start;
   assign b8.instr_valid = instr_valid;
   assign b8.instr_in = instr_in;
   assign b2.start = start;
   assign b2.instr_valid = instr_valid;
   assign b2.instr_in = instr_in;

   branch_scanner #(.DEPTH_W(8), .OP_W(4)) dut8 (.clock(clock), .reset(reset), .bus(b8.slave));
   branch_scanner #(.DEPTH_W(2), .OP_W(4)) dut2 (.clock(clock), .reset(reset), .bus(b2.slave));

   // Behavioural model: what the scanner is doing, not how it is encoded.
   typedef struct {
      bit scanning;
      bit stuck;      // overflowed, waiting for reset
      bit finishing;  // matching bracket just consumed
      bit ov;
      int depth;
   } mdl_t;

   mdl_t m8, m2;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.scanning = 0; m.stuck = 0; m.finishing = 0; m.ov = 0; m.depth = 0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int maxd, bit s, bit v, logic [3:0] op);
      mdl_t n = m;
      if (m.finishing) n.finishing = 0;
      else if (m.stuck) n = m;
      else if (m.scanning) begin
         if (v && op == CBF) begin
            if (m.depth == maxd) begin n.ov = 1; n.stuck = 1; n.scanning = 0; end
            else n.depth = m.depth + 1;
         end else if (v && op == CBB) begin
            if (m.depth == 1) begin n.depth = 0; n.scanning = 0; n.finishing = 1; end
            else n.depth = m.depth - 1;
         end
      end else if (s) begin
         n.scanning = 1; n.depth = 1;
      end
      return n;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m8 = mdl_reset();
         m2 = mdl_reset();
      end else begin
         m8 = mdl_step(m8, 255, start, instr_valid, instr_in);
         m2 = mdl_step(m2, 3, start, instr_valid, instr_in);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_out(mdl_t m, logic [3:0] i);
      return (m.scanning || m.stuck || m.finishing) ? NOP : i;
   endfunction

   always @(negedge clock) begin
      chk("d8.instr_out", 32'(b8.instr_out), 32'(exp_out(m8, instr_in)));
      chk("d8.busy", 32'(b8.busy), 32'(m8.scanning || m8.stuck));
      chk("d8.pc_advance", 32'(b8.pc_advance), 32'(m8.scanning && instr_valid));
      chk("d8.done", 32'(b8.done), 32'(m8.finishing));
      chk("d8.overflow", 32'(b8.overflow), 32'(m8.ov));
      chk("d8.depth", 32'(b8.depth), 32'(m8.depth));
      chk("d2.instr_out", 32'(b2.instr_out), 32'(exp_out(m2, instr_in)));
      chk("d2.busy", 32'(b2.busy), 32'(m2.scanning || m2.stuck));
      chk("d2.pc_advance", 32'(b2.pc_advance), 32'(m2.scanning && instr_valid));
      chk("d2.done", 32'(b2.done), 32'(m2.finishing));
      chk("d2.overflow", 32'(b2.overflow), 32'(m2.ov));
      chk("d2.depth", 32'(b2.depth), 32'(m2.depth));
   end

   // Present inputs, let one rising edge consume them, return shortly after.
   task automatic cyc(input bit s, input bit v, input logic [3:0] op);
      start = s; instr_valid = v; instr_in = op;
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0; instr_valid = 1'b0; instr_in = NOP;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   initial begin
      logic [3:0] seq2 [5];
      int         dep2 [5];
      logic [3:0] ops [9];
      seq2 = '{CBF, INC, CBB, MVR, CBB};
      dep2 = '{2, 2, 1, 1, 0};
      ops  = '{NOP, INC, DEC, MVR, MVL, PSH, POP, CBF, CBB};

      do_reset();
      #1;
      chk("reset.depth", 32'(b8.depth), 32'd0);
      chk("reset.busy", 32'(b8.busy), 32'd0);

      // 1: start; INC, DEC, CBB
      cyc(1, 1, CBF);
      chk("t1.depth", 32'(b8.depth), 32'd1);
      chk("t1.nop", 32'(b8.instr_out), 32'(NOP));
      cyc(0, 1, INC);
      chk("t1.pc_adv", 32'(b8.pc_advance), 32'd1);
      cyc(0, 1, DEC);
      chk("t1.notdone", 32'(b8.done), 32'd0);
      cyc(0, 1, CBB);
      chk("t1.done", 32'(b8.done), 32'd1);
      chk("t1.busy", 32'(b8.busy), 32'd0);
      cyc(0, 1, PSH);
      chk("t1.done_clr", 32'(b8.done), 32'd0);
      chk("t1.pass", 32'(b8.instr_out), 32'(PSH));

      // 2: nested bracket
      cyc(1, 1, CBF);
      chk("t2.depth0", 32'(b8.depth), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, seq2[i]);
         chk($sformatf("t2.depth%0d", i + 1), 32'(b8.depth), 32'(dep2[i]));
         chk($sformatf("t2.done%0d", i + 1), 32'(b8.done), 32'(i == 4));
         if (seq2[i] == MVR) chk("t2.mvr_hidden", 32'(b8.instr_out), 32'(NOP));
      end
      cyc(0, 0, NOP);

      // 3: fetch stall
      cyc(1, 1, CBF);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, CBB);
         chk("t3.hold_depth", 32'(b8.depth), 32'd1);
         chk("t3.hold_pc", 32'(b8.pc_advance), 32'd0);
         chk("t3.hold_busy", 32'(b8.busy), 32'd1);
      end
      cyc(0, 1, CBB);
      chk("t3.done", 32'(b8.done), 32'd1);
      cyc(0, 0, NOP);

      // 4: overflow on the 2-bit instance
      cyc(1, 1, CBF);
      cyc(0, 1, CBF);
      chk("t4.depth2", 32'(b2.depth), 32'd2);
      cyc(0, 1, CBF);
      chk("t4.depth3", 32'(b2.depth), 32'd3);
      chk("t4.no_ov", 32'(b2.overflow), 32'd0);
      cyc(0, 1, CBF);
      chk("t4.ov", 32'(b2.overflow), 32'd1);
      chk("t4.sat", 32'(b2.depth), 32'd3);
      cyc(0, 1, CBB);
      cyc(1, 1, CBF);
      chk("t4.stuck_busy", 32'(b2.busy), 32'd1);
      chk("t4.stuck_ov", 32'(b2.overflow), 32'd1);
      chk("t4.stuck_pc", 32'(b2.pc_advance), 32'd0);
      do_reset();
      #1;
      chk("t4.ov_clr", 32'(b2.overflow), 32'd0);

      // 5: asynchronous reset mid-scan
      cyc(1, 1, CBF);
      cyc(0, 1, CBF);
      #1 reset = 1'b1;
      #1;
      chk("t5.busy", 32'(b8.busy), 32'd0);
      chk("t5.depth", 32'(b8.depth), 32'd0);
      chk("t5.done", 32'(b8.done), 32'd0);
      chk("t5.pass", 32'(b8.instr_out), 32'(CBF));
      @(posedge clock);
      #1 reset = 1'b0;
      cyc(0, 1, PSH);
      chk("t5.after", 32'(b8.instr_out), 32'(PSH));

      // 6: idle pass-through
      cyc(0, 1, POP);
      chk("t6.pass", 32'(b8.instr_out), 32'(POP));
      chk("t6.busy", 32'(b8.busy), 32'd0);
      chk("t6.pc", 32'(b8.pc_advance), 32'd0);
      chk("t6.depth", 32'(b8.depth), 32'd0);

      // Randomised traffic, including occasional asynchronous resets.
      for (int n = 0; n < 4000; n++) begin
         int unsigned r = $urandom_range(0, 99);
         logic [3:0] op;
         if (r < 30) op = CBF;
         else if (r < 55) op = CBB;
         else op = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 249) == 0) begin
            #($urandom_range(1, 6)) reset = 1'b1;
            @(posedge clock);
            #1 reset = 1'b0;
         end
         start = ($urandom_range(0, 9) == 0);
         instr_valid = ($urandom_range(0, 3) != 0);
         instr_in = op;
         @(posedge clock);
         #1;
      end

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
